// File: rtl/canonical_huffman_pkg.sv
// Shared defaults and FSM state encoding for the canonical Huffman decoder.
package canonical_huffman_pkg;
    localparam int HUFF_SYM_W   = 8;
    localparam int HUFF_NSYM    = 256;
    localparam int HUFF_MAX_LEN = 15;
    localparam int LEN_W        = 4;

    typedef enum logic [1:0] {
        ST_BIT = 2'd0,
        ST_OUT = 2'd1,
        ST_ERR = 2'd2
    } state_t;
endpackage

// File: rtl/huff_sym_table.sv
// Symbol table indexed by canonical rank: synchronous write, combinational read, no reset.
module huff_sym_table
    import canonical_huffman_pkg::*;
#(
    parameter int SYM_W = HUFF_SYM_W,
    parameter int NSYM  = HUFF_NSYM,
    parameter int AW    = $clog2(NSYM)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [SYM_W-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [SYM_W-1:0] o_rdata
);
    logic [SYM_W-1:0] r_mem [NSYM];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/canonical_huffman_decoder.sv
// Bit-serial canonical Huffman decoder: per-length code counts, rank-ordered symbol table.
// state  | meaning
// ST_BIT | accepting code bits, bit_ready=1
// ST_OUT | decoded symbol presented, waiting for sym_ready
// ST_ERR | invalid code seen, held until clr or reset
module canonical_huffman_decoder
    import canonical_huffman_pkg::*;
#(
    parameter int SYM_W   = HUFF_SYM_W,
    parameter int NSYM    = HUFF_NSYM,
    parameter int MAX_LEN = HUFF_MAX_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  cnt_we,
    input  logic [LEN_W-1:0]      cnt_len,
    input  logic [$clog2(NSYM):0] cnt_val,
    input  logic                  sym_we,
    input  logic [$clog2(NSYM)-1:0] sym_addr,
    input  logic [SYM_W-1:0]      sym_wdata,
    input  logic                  bit_valid,
    input  logic                  bit_in,
    output logic                  bit_ready,
    output logic                  sym_valid,
    output logic [SYM_W-1:0]      sym_data,
    input  logic                  sym_ready,
    output logic                  err
);
    localparam int AW    = $clog2(NSYM);
    localparam int CNT_W = AW + 1;
    localparam int CW    = MAX_LEN + 1;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_code, r_first;
    logic [CNT_W-1:0] r_index;
    logic [LEN_W-1:0] r_len;
    logic [CNT_W-1:0] r_count [1:MAX_LEN];
    logic [SYM_W-1:0] r_sym_data;
    logic             r_run;

    logic [LEN_W-1:0] w_len1;
    logic [CNT_W-1:0] w_cnt;
    logic [CW-1:0]    w_c, w_diff, w_cnt_ext;
    logic             w_hit, w_accept, w_grow, w_cnt_ok, w_rank_ok;
    logic [31:0]      w_rank;
    logic [SYM_W-1:0] w_tbl_rdata, w_sym;

    huff_sym_table #(.SYM_W(SYM_W), .NSYM(NSYM), .AW(AW)) u_table (
        .clk     (clk),
        .i_we    (sym_we),
        .i_waddr (sym_addr),
        .i_wdata (sym_wdata),
        .i_raddr (w_rank[AW-1:0]),
        .o_rdata (w_tbl_rdata)
    );

    assign w_len1    = r_len + LEN_W'(1);
    assign w_cnt     = r_count[w_len1];
    assign w_c       = CW'({r_code, bit_in});
    assign w_diff    = w_c - r_first;
    assign w_cnt_ext = CW'(w_cnt);
    assign w_hit     = (w_c >= r_first) && (w_diff < w_cnt_ext);
    assign w_accept  = bit_valid && r_run && (r_state == ST_BIT);
    assign w_grow    = 32'(w_len1) < MAX_LEN;
    assign w_cnt_ok  = (cnt_len != '0) && (32'(cnt_len) <= MAX_LEN);
    // Malformed tables can push the rank past the table; those decode to symbol 0.
    assign w_rank    = 32'(r_index) + 32'(w_diff);
    assign w_rank_ok = w_rank < 32'(NSYM);
    assign w_sym     = w_rank_ok ? w_tbl_rdata : '0;
    assign sym_data  = r_sym_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_BIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        bit_ready   = 1'b0;
        sym_valid   = 1'b0;
        err         = 1'b0;
        case (r_state)
            ST_BIT: begin
                bit_ready = r_run;
                if (w_accept) begin
                    if (w_hit)        w_state_nxt = ST_OUT;
                    else if (!w_grow) w_state_nxt = ST_ERR;
                end
            end
            ST_OUT: begin
                sym_valid = 1'b1;
                if (sym_ready) w_state_nxt = ST_BIT;
            end
            ST_ERR:  err = 1'b1;
            default: w_state_nxt = ST_BIT;
        endcase
        if (clr) w_state_nxt = ST_BIT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_code     <= '0;
            r_first    <= '0;
            r_index    <= '0;
            r_len      <= '0;
            r_sym_data <= '0;
            for (int i = 1; i <= MAX_LEN; i++) r_count[i] <= '0;
        end else begin
            r_run <= 1'b1;
            for (int i = 1; i <= MAX_LEN; i++) begin
                if (cnt_we && w_cnt_ok && (cnt_len == LEN_W'(i))) r_count[i] <= cnt_val;
            end
            if (clr || ((r_state == ST_OUT) && sym_ready)) begin
                r_code  <= '0;
                r_first <= '0;
                r_index <= '0;
                r_len   <= '0;
            end else if (w_accept) begin
                if (w_hit) begin
                    r_sym_data <= w_sym;
                end else if (w_grow) begin
                    r_index <= r_index + w_cnt;
                    r_first <= (r_first + w_cnt_ext) << 1;
                    r_code  <= w_c;
                    r_len   <= w_len1;
                end
            end
        end
    end
endmodule

// File: tb/tb_canonical_huffman_decoder.sv
// Directed bench: stimulus pushes expected symbols, a negedge monitor pops and compares.
module tb_canonical_huffman_decoder;
    localparam int SYM_W   = 8;
    localparam int NSYM    = 256;
    localparam int MAX_LEN = 15;

    logic       clk, rst_n, clr, cnt_we, sym_we, bit_valid, bit_in, sym_ready;
    logic [3:0] cnt_len;
    logic [8:0] cnt_val;
    logic [7:0] sym_addr, sym_wdata;
    logic       bit_ready, sym_valid, err;
    logic [7:0] sym_data;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    canonical_huffman_decoder #(.SYM_W(SYM_W), .NSYM(NSYM), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .cnt_we    (cnt_we),
        .cnt_len   (cnt_len),
        .cnt_val   (cnt_val),
        .sym_we    (sym_we),
        .sym_addr  (sym_addr),
        .sym_wdata (sym_wdata),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .bit_ready (bit_ready),
        .sym_valid (sym_valid),
        .sym_data  (sym_data),
        .sym_ready (sym_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst_n && sym_valid && sym_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_sym: got %0h expected none", sym_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (sym_data !== mon_exp) begin
                    n_errors++;
                    $display("FAIL sym_data: got %0h expected %0h", sym_data, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cnt(input logic [3:0] l, input logic [8:0] v);
        cnt_we = 1'b1; cnt_len = l; cnt_val = v;
        tick();
        cnt_we = 1'b0;
    endtask

    task automatic write_sym(input logic [7:0] a, input logic [7:0] d);
        sym_we = 1'b1; sym_addr = a; sym_wdata = d;
        tick();
        sym_we = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        int k;
        k = 0;
        bit_valid = 1'b1;
        bit_in    = b;
        @(negedge clk);
        while (!bit_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bit_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL bit_timeout: got bit_ready=0 expected 1");
        end
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_code(input logic [15:0] bits, input int len, input logic [7:0] sym);
        exp_q.push_back(sym);
        for (int i = len - 1; i >= 0; i--) send_bit(bits[i]);
        @(negedge clk);
        check("sym_latency", 32'(sym_valid), 32'd1);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; cnt_we = 1'b0; sym_we = 1'b0;
        bit_valid = 1'b0; bit_in = 1'b0; sym_ready = 1'b1;
        cnt_len = '0; cnt_val = '0; sym_addr = '0; sym_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bit_ready", 32'(bit_ready), 32'd0);
        check("rst_sym_valid", 32'(sym_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_sym_data", 32'(sym_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_clk", 32'(bit_ready), 32'd0);
        @(negedge clk);
        check("ready_after_clk", 32'(bit_ready), 32'd1);
        tick();

        write_cnt(4'd0, 9'd5);
        write_cnt(4'd1, 9'd1);
        write_cnt(4'd2, 9'd1);
        write_cnt(4'd3, 9'd2);
        write_sym(8'd0, 8'h41);
        write_sym(8'd1, 8'h42);
        write_sym(8'd2, 8'h43);
        write_sym(8'd3, 8'h44);

        send_code(16'b0,   1, 8'h41);
        send_code(16'b10,  2, 8'h42);
        send_code(16'b110, 3, 8'h43);
        send_code(16'b111, 3, 8'h44);

        // Backpressure: symbol must hold while sym_ready is low.
        sym_ready = 1'b0;
        exp_q.push_back(8'h42);
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(sym_valid), 32'd1);
            check("stall_data", 32'(sym_data), 32'h42);
            check("stall_bit_ready", 32'(bit_ready), 32'd0);
        end
        tick();
        sym_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("post_stall_ready", 32'(bit_ready), 32'd1);
        check("post_stall_valid", 32'(sym_valid), 32'd0);
        tick();

        send_bit(1'b1);
        send_bit(1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        send_code(16'b0, 1, 8'h41);

        bit_valid = 1'b1; bit_in = 1'b0; clr = 1'b1;
        tick();
        bit_valid = 1'b0; clr = 1'b0;
        @(negedge clk);
        check("clr_dom_valid", 32'(sym_valid), 32'd0);
        check("clr_dom_ready", 32'(bit_ready), 32'd1);
        tick();

        write_cnt(4'd1, 9'd0);
        write_cnt(4'd2, 9'd0);
        write_cnt(4'd3, 9'd0);
        for (int i = 0; i < 14; i++) send_bit(1'b1);
        @(negedge clk);
        check("err_before_15", 32'(err), 32'd0);
        check("ready_before_15", 32'(bit_ready), 32'd1);
        tick();
        send_bit(1'b1);
        @(negedge clk);
        check("err_set", 32'(err), 32'd1);
        check("err_bit_ready", 32'(bit_ready), 32'd0);
        check("err_sym_valid", 32'(sym_valid), 32'd0);
        bit_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        tick();
        bit_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("err_cleared", 32'(err), 32'd0);
        check("err_clr_ready", 32'(bit_ready), 32'd1);
        tick();

        // Length-9 codes with a count large enough to index past the table.
        write_cnt(4'd9, 9'd511);
        send_code(16'b1_0000_0000, 9, 8'h00);
        check("oor_no_err", 32'(err), 32'd0);
        send_code(16'b0_0000_0001, 9, 8'h42);

        write_cnt(4'd9, 9'd0);
        write_cnt(4'd1, 9'd1);
        sym_ready = 1'b0;
        send_bit(1'b0);
        @(negedge clk);
        check("pre_rst_valid", 32'(sym_valid), 32'd1);
        check("pre_rst_data", 32'(sym_data), 32'h41);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(sym_valid), 32'd0);
        check("async_rst_data", 32'(sym_data), 32'd0);
        tick();
        rst_n = 1'b1;
        sym_ready = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) send_bit(1'b0);
        @(negedge clk);
        check("post_rst_err", 32'(err), 32'd1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
